// File: rtl/ace_pkg.sv
// rtl/ace_pkg.sv - ACE snoop line states, CR response layout, ACSNOOP codes and snoop decision function
package ace_pkg;

  typedef enum logic [2:0] {
    LS_I  = 3'd0,
    LS_UC = 3'd1,
    LS_UD = 3'd2,
    LS_SC = 3'd3,
    LS_SD = 3'd4
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESULT,
    ST_CR,
    ST_CD,
    ST_UPD
  } snp_state_t;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } cr_resp_t;

  typedef struct packed {
    cr_resp_t    resp;
    line_state_t new_state;
    logic        upd;
  } snoop_dec_t;

  localparam logic [3:0] SNP_READ_ONCE       = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED     = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN      = 4'b0010;
  localparam logic [3:0] SNP_READ_NSD        = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE     = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED    = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID   = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID    = 4'b1101;

  // Miss/Invalid answers all-zero; unknown opcodes on a valid line answer Error only.
  // An update is requested only when the line state actually changes.
  function automatic snoop_dec_t snoop_decide(input logic [3:0] snoop, input logic hit,
                                              input line_state_t state);
    snoop_dec_t d;
    logic dirty;
    d = '0;
    d.new_state = state;
    dirty = (state == LS_UD) || (state == LS_SD);
    if (hit && (state != LS_I)) begin
      case (snoop)
        SNP_READ_ONCE: begin
          d.resp.data_transfer = 1'b1;
          d.resp.is_shared     = 1'b1;
        end
        SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
          d.resp.data_transfer = 1'b1;
          d.resp.is_shared     = 1'b1;
          d.resp.pass_dirty    = dirty;
          d.new_state          = LS_SC;
        end
        SNP_CLEAN_SHARED: begin
          d.resp.is_shared     = 1'b1;
          d.resp.data_transfer = dirty;
          d.resp.pass_dirty    = dirty;
          if (dirty) d.new_state = LS_SC;
        end
        SNP_READ_UNIQUE: begin
          d.resp.data_transfer = 1'b1;
          d.resp.pass_dirty    = dirty;
          d.new_state          = LS_I;
        end
        SNP_CLEAN_INVALID: begin
          d.resp.data_transfer = dirty;
          d.resp.pass_dirty    = dirty;
          d.new_state          = LS_I;
        end
        SNP_MAKE_INVALID: begin
          d.new_state = LS_I;
        end
        default: begin
          d.resp.error = 1'b1;
        end
      endcase
      if (!d.resp.error) begin
        d.resp.was_unique = (state == LS_UC) || (state == LS_UD);
        d.upd             = (d.new_state != state);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/ace_snoop_cd_streamer.sv
// rtl/ace_snoop_cd_streamer.sv - CD channel beat counter, data array read issue and output register
module ace_snoop_cd_streamer #(
  parameter int DataWidth = 64,
  parameter int LineBeats = 4,
  parameter int IdxWidth  = $clog2(LineBeats)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_start,
  output logic                 o_data_rd,
  output logic [IdxWidth-1:0]  o_data_beat,
  input  logic [DataWidth-1:0] i_data_rdata,
  output logic                 o_cd_valid,
  input  logic                 i_cd_ready,
  output logic [DataWidth-1:0] o_cd_data,
  output logic                 o_cd_last,
  output logic                 o_done
);

  logic                 r_active;
  logic [IdxWidth-1:0]  r_cnt;
  logic                 r_pend;
  logic                 r_pend_last;
  logic                 r_out_valid;
  logic [DataWidth-1:0] r_out_data;
  logic                 r_out_last;

  logic w_hs;
  logic w_load;
  logic w_issue;
  logic w_cnt_last;

  // A read whose data has not been loaded keeps the array output stable (no new read is issued),
  // so pending data may wait for the output register without a skid buffer.
  assign w_hs       = r_out_valid && i_cd_ready;
  assign w_load     = r_pend && (!r_out_valid || w_hs);
  assign w_issue    = r_active && (!r_pend || w_load);
  assign w_cnt_last = (r_cnt == IdxWidth'(LineBeats - 1));

  assign o_data_rd   = w_issue;
  assign o_data_beat = r_cnt;
  assign o_cd_valid  = r_out_valid;
  assign o_cd_data   = r_out_data;
  assign o_cd_last   = r_out_last;
  assign o_done      = w_hs && r_out_last;

  // Read issue side: beat counter starts at 0 for every line and wraps at LineBeats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active    <= 1'b0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else if (i_start) begin
      r_active    <= 1'b1;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else if (w_issue) begin
      r_cnt       <= r_cnt + 1'b1;
      r_pend      <= 1'b1;
      r_pend_last <= w_cnt_last;
      if (w_cnt_last) r_active <= 1'b0;
    end else if (w_load) begin
      r_pend <= 1'b0;
    end
  end

  // Output register: loads pending read data when empty or draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (i_start) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= i_data_rdata;
      r_out_last  <= r_pend_last;
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// rtl/ace_snoop_responder.sv - ACE snoop slave: lookup, CR response, CD line data, state update (option ACE_SNOOP_EXCL_MON_EN)
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineBeats = 4,
  parameter int IdxWidth  = $clog2(LineBeats)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 tag_req_o,
  output logic [AddrWidth-1:0] tag_addr_o,
  input  logic                 tag_gnt_i,
  input  logic                 tag_hit_i,
  input  logic [2:0]           tag_state_i,
  output logic                 data_rd_o,
  output logic [IdxWidth-1:0]  data_beat_o,
  input  logic [DataWidth-1:0] data_rdata_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [2:0]           upd_state_o
`ifdef ACE_SNOOP_EXCL_MON_EN
  ,
  output logic                 excl_clr_o,
  output logic [AddrWidth-1:0] excl_clr_addr_o
`endif
);

  localparam int LineOffW = $clog2(LineBeats * DataWidth / 8);

  snp_state_t           r_state;
  logic [AddrWidth-1:0] r_addr;
  logic [3:0]           r_snoop;
  cr_resp_t             r_resp;
  line_state_t          r_new_state;
  logic                 r_upd;
  logic                 r_ac_ready;
  logic                 r_tag_req;
  logic                 r_cr_valid;
  logic                 r_upd_valid;

  snoop_dec_t           w_dec;
  logic                 w_cd_start;
  logic                 w_cd_done;
  logic [AddrWidth-1:0] w_line_addr;
  logic                 w_unused;

  assign w_dec       = snoop_decide(r_snoop, tag_hit_i, line_state_t'(tag_state_i));
  assign w_cd_start  = (r_state == ST_CR) && cr_ready_i && r_resp.data_transfer;
  assign w_line_addr = {r_addr[AddrWidth-1:LineOffW], {LineOffW{1'b0}}};
  assign w_unused    = ^{ac_prot_i, r_addr[LineOffW-1:0]};

  assign ac_ready_o  = r_ac_ready;
  assign tag_req_o   = r_tag_req;
  assign tag_addr_o  = w_line_addr;
  assign cr_valid_o  = r_cr_valid;
  assign cr_resp_o   = r_resp;
  assign upd_valid_o = r_upd_valid;
  assign upd_state_o = r_new_state;

`ifdef ACE_SNOOP_EXCL_MON_EN
  assign excl_clr_o      = r_upd_valid && upd_ready_i && (r_new_state == LS_I);
  assign excl_clr_addr_o = w_line_addr;
`endif

  // Snoop sequencing FSM with registered handshake outputs; one snoop in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_snoop     <= '0;
      r_resp      <= '0;
      r_new_state <= LS_I;
      r_upd       <= 1'b0;
      r_ac_ready  <= 1'b1;
      r_tag_req   <= 1'b0;
      r_cr_valid  <= 1'b0;
      r_upd_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (ac_valid_i) begin
          r_addr     <= ac_addr_i;
          r_snoop    <= ac_snoop_i;
          r_ac_ready <= 1'b0;
          r_tag_req  <= 1'b1;
          r_state    <= ST_LOOKUP;
        end
        ST_LOOKUP: if (tag_gnt_i) begin
          r_tag_req <= 1'b0;
          r_state   <= ST_RESULT;
        end
        ST_RESULT: begin
          r_resp      <= w_dec.resp;
          r_new_state <= w_dec.new_state;
          r_upd       <= w_dec.upd;
          r_cr_valid  <= 1'b1;
          r_state     <= ST_CR;
        end
        ST_CR: if (cr_ready_i) begin
          r_cr_valid <= 1'b0;
          if (r_resp.data_transfer) begin
            r_state <= ST_CD;
          end else if (r_upd) begin
            r_upd_valid <= 1'b1;
            r_state     <= ST_UPD;
          end else begin
            r_ac_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_CD: if (w_cd_done) begin
          if (r_upd) begin
            r_upd_valid <= 1'b1;
            r_state     <= ST_UPD;
          end else begin
            r_ac_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_UPD: if (upd_ready_i) begin
          r_upd_valid <= 1'b0;
          r_ac_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ace_snoop_cd_streamer #(
    .DataWidth(DataWidth),
    .LineBeats(LineBeats),
    .IdxWidth (IdxWidth)
  ) u_cd_streamer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_start     (w_cd_start),
    .o_data_rd   (data_rd_o),
    .o_data_beat (data_beat_o),
    .i_data_rdata(data_rdata_i),
    .o_cd_valid  (cd_valid_o),
    .i_cd_ready  (cd_ready_i),
    .o_cd_data   (cd_data_o),
    .o_cd_last   (cd_last_o),
    .o_done      (w_cd_done)
  );

endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb/tb_ace_snoop_responder.sv - directed self-checking bench for ace_snoop_responder
module tb_ace_snoop_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ac_valid_i;
  logic        ac_ready_o;
  logic [63:0] ac_addr_i;
  logic [3:0]  ac_snoop_i;
  logic [2:0]  ac_prot_i;
  logic        cr_valid_o;
  logic        cr_ready_i;
  logic [4:0]  cr_resp_o;
  logic        cd_valid_o;
  logic        cd_ready_i;
  logic [63:0] cd_data_o;
  logic        cd_last_o;
  logic        tag_req_o;
  logic [63:0] tag_addr_o;
  logic        tag_gnt_i;
  logic        tag_hit_i;
  logic [2:0]  tag_state_i;
  logic        data_rd_o;
  logic [1:0]  data_beat_o;
  logic [63:0] data_rdata_i = '0;
  logic        upd_valid_o;
  logic        upd_ready_i;
  logic [2:0]  upd_state_o;

  int n_cmp = 0;
  int n_err = 0;
  int pat_seed = 0;

  logic [4:0]  obs_resp;
  int          obs_cr_k;
  logic [63:0] obs_data[$];
  int          obs_k[$];
  int          obs_last_pos;
  logic        obs_upd;
  logic [2:0]  obs_upd_state;
  int          obs_ready_k;
  logic        obs_timeout;
  logic        obs_cd_before_cr;
  logic [63:0] obs_tag_addr;

  always #5 clk_i = ~clk_i;

  ace_snoop_responder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ac_valid_i  (ac_valid_i),
    .ac_ready_o  (ac_ready_o),
    .ac_addr_i   (ac_addr_i),
    .ac_snoop_i  (ac_snoop_i),
    .ac_prot_i   (ac_prot_i),
    .cr_valid_o  (cr_valid_o),
    .cr_ready_i  (cr_ready_i),
    .cr_resp_o   (cr_resp_o),
    .cd_valid_o  (cd_valid_o),
    .cd_ready_i  (cd_ready_i),
    .cd_data_o   (cd_data_o),
    .cd_last_o   (cd_last_o),
    .tag_req_o   (tag_req_o),
    .tag_addr_o  (tag_addr_o),
    .tag_gnt_i   (tag_gnt_i),
    .tag_hit_i   (tag_hit_i),
    .tag_state_i (tag_state_i),
    .data_rd_o   (data_rd_o),
    .data_beat_o (data_beat_o),
    .data_rdata_i(data_rdata_i),
    .upd_valid_o (upd_valid_o),
    .upd_ready_i (upd_ready_i),
    .upd_state_o (upd_state_o)
  );

  function automatic logic [63:0] beat_data(input logic [1:0] b);
    return 64'hCAFE_0000_0000_0000 | (64'(pat_seed) << 16) | 64'(b);
  endfunction

  // Tag array grants immediately; data array answers one cycle after a read strobe and holds otherwise.
  assign tag_gnt_i = tag_req_o;
  always @(posedge clk_i) if (data_rd_o) data_rdata_i <= beat_data(data_beat_o);

  task automatic run_snoop(input logic [63:0] addr, input logic [3:0] snp, input logic hit,
                           input logic [2:0] st, input bit toggle);
    obs_resp = 5'h1f; obs_cr_k = -1; obs_data.delete(); obs_k.delete(); obs_last_pos = -1;
    obs_upd = 1'b0; obs_upd_state = 3'h7; obs_ready_k = -1; obs_timeout = 1'b1;
    obs_cd_before_cr = 1'b0; obs_tag_addr = '1;
    tag_hit_i = hit; tag_state_i = st; cd_ready_i = 1'b1;
    for (int w = 0; w < 20 && !ac_ready_o; w++) begin @(posedge clk_i); #1; end
    ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = snp; ac_prot_i = 3'b010;
    @(posedge clk_i); #1;
    ac_valid_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      cd_ready_i = toggle ? (k % 2 == 1) : 1'b1;
      if (tag_req_o) obs_tag_addr = tag_addr_o;
      if (cr_valid_o && cr_ready_i) begin obs_resp = cr_resp_o; obs_cr_k = k; end
      if (cd_valid_o && cd_ready_i) begin
        if (obs_cr_k < 0) obs_cd_before_cr = 1'b1;
        obs_data.push_back(cd_data_o);
        obs_k.push_back(k);
        if (cd_last_o) obs_last_pos = obs_data.size() - 1;
      end
      if (upd_valid_o && upd_ready_i) begin obs_upd = 1'b1; obs_upd_state = upd_state_o; end
      if (ac_ready_o && obs_cr_k > 0) begin obs_ready_k = k; obs_timeout = 1'b0; break; end
      @(posedge clk_i); #1;
    end
    cd_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
    cr_ready_i = 1'b1; cd_ready_i = 1'b1; upd_ready_i = 1'b1; tag_hit_i = 1'b0; tag_state_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({ac_ready_o, cr_valid_o, cd_valid_o, tag_req_o, data_rd_o, upd_valid_o, cd_last_o} !== 7'b1000000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 1000000",
        {ac_ready_o, cr_valid_o, cd_valid_o, tag_req_o, data_rd_o, upd_valid_o, cd_last_o});
    end
    n_cmp++;
    if (cr_resp_o !== 5'b0) begin n_err++; $display("FAIL reset_resp: got %b expected 00000", cr_resp_o); end
    n_cmp++;
    if (data_beat_o !== 2'd0) begin n_err++; $display("FAIL reset_beat: got %0d expected 0", data_beat_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic check_full_line(input string nm, input bit consecutive);
    n_cmp++;
    if (obs_data.size() != 4) begin
      n_err++; $display("FAIL %s_nbeats: got %0d expected 4", nm, obs_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_data[i] !== beat_data(2'(i))) begin
          n_err++; $display("FAIL %s_beat%0d: got %h expected %h", nm, i, obs_data[i], beat_data(2'(i)));
        end
        if (consecutive && i > 0) begin
          n_cmp++;
          if (obs_k[i] != obs_k[i-1] + 1) begin
            n_err++; $display("FAIL %s_gap%0d: got cycle %0d expected %0d", nm, i, obs_k[i], obs_k[i-1] + 1);
          end
        end
      end
    end
    n_cmp++;
    if (obs_last_pos != 3) begin n_err++; $display("FAIL %s_last: got %0d expected 3", nm, obs_last_pos); end
    n_cmp++;
    if (obs_cd_before_cr !== 1'b0) begin n_err++; $display("FAIL %s_cr_first: got cd before cr expected cr first", nm); end
  endtask

  task automatic test_ud_read_shared();
    pat_seed = 1;
    run_snoop(64'h1000, 4'b0001, 1'b1, 3'd2, 1'b0);
    n_cmp++;
    if (obs_timeout !== 1'b0) begin n_err++; $display("FAIL rs_timeout: got timeout expected completion"); end
    n_cmp++;
    if (obs_resp !== 5'b11101) begin n_err++; $display("FAIL rs_resp: got %b expected 11101", obs_resp); end
    n_cmp++;
    if (obs_tag_addr !== 64'h1000) begin n_err++; $display("FAIL rs_tag_addr: got %h expected 1000", obs_tag_addr); end
    check_full_line("rs", 1'b1);
    n_cmp++;
    if (obs_upd !== 1'b1 || obs_upd_state !== 3'd3) begin
      n_err++; $display("FAIL rs_upd: got %b/%0d expected 1/3", obs_upd, obs_upd_state);
    end
  endtask

  task automatic test_sc_clean_invalid();
    run_snoop(64'h1000, 4'b1001, 1'b1, 3'd3, 1'b0);
    n_cmp++;
    if (obs_resp !== 5'b00000) begin n_err++; $display("FAIL ci_resp: got %b expected 00000", obs_resp); end
    n_cmp++;
    if (obs_data.size() != 0) begin n_err++; $display("FAIL ci_nbeats: got %0d expected 0", obs_data.size()); end
    n_cmp++;
    if (obs_upd !== 1'b1 || obs_upd_state !== 3'd0) begin
      n_err++; $display("FAIL ci_upd: got %b/%0d expected 1/0", obs_upd, obs_upd_state);
    end
  endtask

  task automatic test_miss_read_unique();
    run_snoop(64'h3040, 4'b0111, 1'b0, 3'd0, 1'b0);
    n_cmp++;
    if (obs_resp !== 5'b00000) begin n_err++; $display("FAIL miss_resp: got %b expected 00000", obs_resp); end
    n_cmp++;
    if (obs_data.size() != 0 || obs_upd !== 1'b0) begin
      n_err++; $display("FAIL miss_nocd_noupd: got beats %0d upd %b expected 0 0", obs_data.size(), obs_upd);
    end
    n_cmp++;
    if (obs_ready_k != 4) begin n_err++; $display("FAIL miss_ready_lat: got %0d expected 4", obs_ready_k); end
  endtask

  task automatic test_uc_read_once_toggle();
    pat_seed = 2;
    run_snoop(64'h2018, 4'b0000, 1'b1, 3'd1, 1'b1);
    n_cmp++;
    if (obs_resp !== 5'b11001) begin n_err++; $display("FAIL ro_resp: got %b expected 11001", obs_resp); end
    n_cmp++;
    if (obs_tag_addr !== 64'h2000) begin n_err++; $display("FAIL ro_tag_addr: got %h expected 2000", obs_tag_addr); end
    check_full_line("ro", 1'b0);
    n_cmp++;
    if (obs_upd !== 1'b0) begin n_err++; $display("FAIL ro_noupd: got %b expected 0", obs_upd); end
  endtask

  task automatic test_bad_snoop();
    run_snoop(64'h1000, 4'b1110, 1'b1, 3'd2, 1'b0);
    n_cmp++;
    if (obs_resp !== 5'b00010) begin n_err++; $display("FAIL bad_resp: got %b expected 00010", obs_resp); end
    n_cmp++;
    if (obs_data.size() != 0 || obs_upd !== 1'b0) begin
      n_err++; $display("FAIL bad_nocd_noupd: got beats %0d upd %b expected 0 0", obs_data.size(), obs_upd);
    end
  endtask

  task automatic test_reset_mid_cd();
    bit hit_beat2;
    pat_seed = 3;
    hit_beat2 = 1'b0;
    tag_hit_i = 1'b1; tag_state_i = 3'd2; cd_ready_i = 1'b1;
    ac_valid_i = 1'b1; ac_addr_i = 64'h1000; ac_snoop_i = 4'b0001;
    @(posedge clk_i); #1;
    ac_valid_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (cd_valid_o && cd_data_o === beat_data(2'd2)) begin
        rst_ni = 1'b0;
        #1;
        hit_beat2 = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    n_cmp++;
    if (!hit_beat2) begin n_err++; $display("FAIL rst_mid_reach: got no beat 2 expected beat 2"); end
    n_cmp++;
    if ({ac_ready_o, cr_valid_o, cd_valid_o, tag_req_o, data_rd_o, upd_valid_o, cd_last_o} !== 7'b1000000) begin
      n_err++; $display("FAIL rst_mid_ctrl: got %b expected 1000000",
        {ac_ready_o, cr_valid_o, cd_valid_o, tag_req_o, data_rd_o, upd_valid_o, cd_last_o});
    end
    n_cmp++;
    if (cr_resp_o !== 5'b0 || data_beat_o !== 2'd0) begin
      n_err++; $display("FAIL rst_mid_regs: got resp %b beat %0d expected 00000 0", cr_resp_o, data_beat_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    pat_seed = 4;
    run_snoop(64'h1000, 4'b0001, 1'b1, 3'd2, 1'b0);
    n_cmp++;
    if (obs_resp !== 5'b11101) begin n_err++; $display("FAIL post_rst_resp: got %b expected 11101", obs_resp); end
    check_full_line("post_rst", 1'b1);
    n_cmp++;
    if (obs_upd !== 1'b1 || obs_upd_state !== 3'd3) begin
      n_err++; $display("FAIL post_rst_upd: got %b/%0d expected 1/3", obs_upd, obs_upd_state);
    end
  endtask

  initial begin
    test_reset();
    test_ud_read_shared();
    test_sc_clean_invalid();
    test_miss_read_unique();
    test_uc_read_once_toggle();
    test_bad_snoop();
    test_reset_mid_cd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Cache-side ACE snoop slave, placed between the snoop crossbar and a cached master's tag/data arrays.
- Accepts AC snoop requests and looks up the line state.
- Returns the CR response, streams the line on CD when DataTransfer=1, then writes back the new line state.
- One snoop in flight; AC is backpressured until the current snoop completes.

Parameters:
- AddrWidth, 64, AC address width.
- DataWidth, 64, CD data width.
- LineBeats, 4, CD beats per cache line (power of 2, >=2).
- IdxWidth, $clog2(LineBeats), beat counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- ac_valid_i  in  1  snoop request valid
- ac_ready_o  out  1  snoop request ready
- ac_addr_i  in  AddrWidth  snoop address
- ac_snoop_i  in  4  ACSNOOP
- ac_prot_i  in  3  ACPROT (ignored, kept for tracing)
- cr_valid_o  out  1  snoop response valid
- cr_ready_i  in  1  snoop response ready
- cr_resp_o  out  5  {WasUnique,IsShared,PassDirty,Error,DataTransfer}
- cd_valid_o  out  1  snoop data valid
- cd_ready_i  in  1  snoop data ready
- cd_data_o  out  DataWidth  snoop data
- cd_last_o  out  1  last beat
- tag_req_o  out  1  tag lookup strobe
- tag_addr_o  out  AddrWidth  line-aligned lookup address
- tag_gnt_i  in  1  lookup granted; result valid next cycle
- tag_hit_i  in  1  lookup hit
- tag_state_i  in  3  line_state_t of hit line
- data_rd_o  out  1  data array read strobe; data valid next cycle
- data_beat_o  out  IdxWidth  beat index
- data_rdata_i  in  DataWidth  read data
- upd_valid_o  out  1  state update strobe
- upd_ready_i  in  1  state update accepted
- upd_state_o  out  3  new line state

Behaviour:
- Reset:
  - State IDLE.
  - ac_ready_o=1.
  - All other valids and strobes 0.
  - cr_resp_o=0.
  - Beat counters 0.
- FSM: IDLE -> LOOKUP -> RESULT -> CR -> [CD] -> UPD -> IDLE.
- IDLE:
  - ac_ready_o=1.
  - On AC handshake, latch addr and snoop, go to LOOKUP.
- LOOKUP:
  - tag_req_o=1, held until tag_gnt_i.
  - Next cycle capture hit/state and go to RESULT.
- RESULT (1 cycle):
  - Compute resp and next state; register both.
  - Go to CR.
- Decision rules, line states I/UC/UD/SC/SD:
  - Miss or I: resp=0, no update.
  - ACSNOOP not in {0000,0001,0010,0011,0111,1000,1001,1101}: resp Error=1 only, no update.
  - WasUnique = (UC|UD).
  - Dirty hit (UD/SD):
    - ReadOnce: DT=1, IS=1, state kept.
    - ReadShared, ReadClean, ReadNotSharedDirty, CleanShared: DT=1, PD=1, IS=1, new state SC.
    - ReadUnique, CleanInvalid: DT=1, PD=1, new state I.
    - MakeInvalid: DT=0, new state I.
  - Clean hit (UC/SC):
    - ReadOnce, ReadShared, ReadClean, ReadNotSharedDirty: DT=1, IS=1; new state SC, except ReadOnce keeps state.
    - CleanShared: IS=1, state kept.
    - ReadUnique: DT=1, new state I.
    - CleanInvalid, MakeInvalid: DT=0, new state I.
- CR:
  - cr_valid_o=1; resp stable until handshake.
  - On handshake go to CD if DT=1, else UPD if an update is needed, else IDLE.
  - CR always precedes the first CD beat.
- CD:
  - Read beats 0..LineBeats-1 starting at wrap offset 0.
  - Single output register: data_rd_o issued only when the register is empty or draining this cycle.
  - Sustains 1 beat/cycle under cd_ready_i=1.
  - cd_last_o=1 on beat LineBeats-1.
  - No bubble or duplicate beats under arbitrary cd_ready_i toggling.
  - On last-beat handshake go to UPD, or to IDLE if no update is needed.
- UPD:
  - upd_valid_o=1 until upd_ready_i; then IDLE.
  - ac_ready_o reasserts in the IDLE cycle.
- Beat counter wraps at LineBeats and is cleared on entry to CD.
- Reset mid-operation aborts immediately and returns to reset values; partial CD bursts are not resumed.

Optional Feature:
- Macro: ACE_SNOOP_EXCL_MON_EN.
- Defined:
  - Adds output excl_clr_o (1) and excl_clr_addr_o (AddrWidth).
  - Pulses for exactly one cycle, with the line address, on the upd handshake whose new state is I.
  - Reset 0.
- Undefined: ports absent, no logic.

Decomposition:
- ace_pkg receives:
  - line_state_t enum (I=0, UC, UD, SC, SD).
  - cr_resp_t packed struct.
  - ACSNOOP localparams.
  - Function snoop_decide(snoop, hit, state) returning {resp, new_state, upd}.
- Sub-module ace_snoop_cd_streamer: beat counter, read issue and output register for the CD channel.

Test Plan:
- UD line, ReadShared at 0x1000, cd_ready=1:
  - CR resp=5'b11101.
  - 4 CD beats on consecutive cycles, last on beat 3.
  - Update SC.
- SC line, CleanInvalid: CR resp=0, no CD, update I; with EXCL_MON_EN, excl_clr_o pulses with addr 0x1000.
- Miss, ReadUnique: CR resp=0, no CD, no upd_valid_o, ac_ready_o high again 4 cycles after AC.
- UC line, ReadOnce, cd_ready toggling 1010...: CR resp=5'b11001; beats 0..3 in order, no duplicates; no update.
- ACSNOOP=4'b1110: CR resp=5'b00010, no CD, no update.
- Reset asserted during CD beat 2: all outputs return to reset values; next snoop completes normally.
